// File: rtl/inst_buffer_pkg.sv
// Shared types and helpers for the instruction buffer between fetch and dispatch.
package inst_buffer_pkg;

  localparam int unsigned IB_N    = 2;   // lanes in / lanes out per cycle
  localparam int unsigned IB_SZ   = 16;  // default buffer depth (power of two)
  localparam int unsigned IB_XLEN = 32;  // instruction / PC width

  // One buffered instruction with its fetch PC and predicted next PC.
  typedef struct packed {
    logic [IB_XLEN-1:0] inst;
    logic [IB_XLEN-1:0] pc;
    logic [IB_XLEN-1:0] npc;
  } ib_entry_t;

  // Number of set bits in a lane-valid mask.
  function automatic int unsigned popcount(input logic [31:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < 32; i++) c += 32'(v[i]);
    return c;
  endfunction

  // True when v is a prefix mask (contiguous ones from bit 0 upward).
  function automatic logic is_prefix(input logic [31:0] v);
    return (v & (v + 32'd1)) == 32'd0;
  endfunction

endpackage

// File: rtl/inst_buffer_if.sv
// Fetch-side and dispatch-side lane bundle of the instruction buffer.
// master: fetch/dispatch environment, slave: the buffer itself.
interface inst_buffer_if
  import inst_buffer_pkg::*;
#(
  parameter int unsigned N     = IB_N,
  parameter int unsigned DEPTH = IB_SZ,
  parameter int unsigned XLEN  = IB_XLEN
) ();

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [N-1:0]      if_valid;
  logic [N*XLEN-1:0] if_inst;
  logic [N*XLEN-1:0] if_pc;
  logic [N*XLEN-1:0] if_npc;
  logic              ib_ready;
  logic              structural_hazard;
  logic              squash;
  logic [N-1:0]      id_valid;
  logic [N*XLEN-1:0] id_inst;
  logic [N*XLEN-1:0] id_pc;
  logic [N*XLEN-1:0] id_npc;
  logic [CNT_W-1:0]  ib_count;

  modport master (
    output if_valid, if_inst, if_pc, if_npc, structural_hazard, squash,
    input  ib_ready, id_valid, id_inst, id_pc, id_npc, ib_count
  );

  modport slave (
    input  if_valid, if_inst, if_pc, if_npc, structural_hazard, squash,
    output ib_ready, id_valid, id_inst, id_pc, id_npc, ib_count
  );

endinterface

// File: rtl/inst_buffer.sv
// Circular instruction queue between fetch and the ooo dispatch stage.
// Accepts up to N lanes per cycle, presents up to N oldest-first, holds on
// structural_hazard and flushes on squash.
// Optional feature: define IB_BYPASS_EN for a 0-cycle fetch-to-dispatch path
// when the buffer is empty.
module inst_buffer
  import inst_buffer_pkg::*;
#(
  parameter int unsigned N     = IB_N,
  parameter int unsigned DEPTH = IB_SZ
) (
  input  logic         clock,
  input  logic         reset,
  inst_buffer_if.slave bus
);

  localparam int unsigned XLEN  = IB_XLEN;
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] N_C       = CNT_W'(N);
  localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - N);

  ib_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic             ready_c;
  logic [CNT_W-1:0] enq_cnt;
  logic [CNT_W-1:0] deq_cnt;
  ib_entry_t        fetch_lane [N];
  ib_entry_t        out_lane [N];
  logic [N-1:0]     out_valid;

`ifdef IB_BYPASS_EN
  logic bypass_c;
  // Empty buffer and no flush: fetch lanes go straight to dispatch.
  assign bypass_c = (count == '0) && !bus.squash;
`endif

  // Room for a full fetch group, judged on registered occupancy only.
  assign ready_c = (count <= READY_MAX);

  // Unpack the flat fetch lanes into entries.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      fetch_lane[i] = '{inst: bus.if_inst[i*XLEN +: XLEN],
                        pc:   bus.if_pc[i*XLEN +: XLEN],
                        npc:  bus.if_npc[i*XLEN +: XLEN]};
    end
  end

  // Per-cycle enqueue and dequeue amounts.
  always_comb begin
    enq_cnt = '0;
    deq_cnt = '0;
    if (ready_c) enq_cnt = CNT_W'(popcount(32'(bus.if_valid)));
`ifdef IB_BYPASS_EN
    // Bypassed lanes that dispatch accepts are never written.
    if (bypass_c && !bus.structural_hazard) enq_cnt = '0;
`endif
    if (!bus.structural_hazard && !bus.squash) deq_cnt = (count < N_C) ? count : N_C;
  end

  // Head/tail/occupancy; squash empties the queue and drops this cycle's enqueue.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (bus.squash) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(deq_cnt);
      tail  <= tail + PTR_W'(enq_cnt);
      count <= count + enq_cnt - deq_cnt;
    end
  end

  // Entry storage; contents are don't-care until counted as occupied.
  always_ff @(posedge clock) begin
    for (int i = 0; i < N; i++) begin
      if (!bus.squash && (CNT_W'(i) < enq_cnt)) mem[tail + PTR_W'(i)] <= fetch_lane[i];
    end
  end

  // Dispatch packet: oldest entries first, blanked during squash.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      out_lane[i]  = mem[head + PTR_W'(i)];
      out_valid[i] = (CNT_W'(i) < count) && !bus.squash;
    end
`ifdef IB_BYPASS_EN
    if (bypass_c) begin
      out_lane  = fetch_lane;
      out_valid = bus.if_valid;
    end
`endif
  end

  // Flatten lanes back onto the dispatch bus.
  for (genvar g = 0; g < N; g++) begin : g_lane
    assign bus.id_inst[g*XLEN +: XLEN] = out_lane[g].inst;
    assign bus.id_pc[g*XLEN +: XLEN]   = out_lane[g].pc;
    assign bus.id_npc[g*XLEN +: XLEN]  = out_lane[g].npc;
  end

  assign bus.id_valid = out_valid;
  assign bus.ib_ready = ready_c;
  assign bus.ib_count = count;

  // Fetch lanes must form a prefix mask.
  a_if_valid_prefix: assert property (@(posedge clock) disable iff (reset)
                                      is_prefix(32'(bus.if_valid)));

endmodule
